core_interface: RTL and testbench



---
 rtl/core_interface.sv | 66 ++++++
 tb/tb_core_interface.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core_interface.sv
// Register front end for one compute core: decodes WRITE/READ in its address window, one-clock
// latency for writes and reads, no handshake or backpressure (every instruction completes in one cycle).
module core_interface #(
   parameter int START_ADDRESS    = 0,
   parameter int END_ADDRESS      = 2,
   parameter int TOTAL_PARAMETERS = 2
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [7:0]                      instruction,
   input  logic [23:0]                     address,
   input  logic [31:0]                     value,
   output logic [31:0]                     output_value,
   output logic                            enable,
   output logic [32*TOTAL_PARAMETERS-1:0]  core_inputs,
   input  logic [31:0]                     core_output
);

   localparam logic [7:0]  OP_WRITE = 8'h01;
   localparam logic [7:0]  OP_READ  = 8'h02;
   localparam logic [23:0] LP_START = 24'(START_ADDRESS);
   localparam logic [23:0] LP_SPAN  = 24'(END_ADDRESS - START_ADDRESS);
   localparam logic [23:0] LP_TOTAL = 24'(TOTAL_PARAMETERS);

   logic [32*TOTAL_PARAMETERS-1:0] r_params;
   logic [31:0]                    r_out;
   logic [23:0]                    w_offset;
   logic                           w_is_param;
   logic [31:0]                    w_rd_param;

   // Addresses below the window wrap to a huge offset, so one unsigned compare covers both bounds.
   assign w_offset   = address - LP_START;
   assign enable     = (w_offset <= LP_SPAN);
   assign w_is_param = (w_offset < LP_TOTAL);

   always_comb begin
      w_rd_param = '0;
      for (int i = 0; i < TOTAL_PARAMETERS; i++) begin
         if (w_offset == 24'(i)) begin
            w_rd_param = r_params[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_params <= '0;
         r_out    <= '0;
      end else begin
         if (enable && instruction == OP_WRITE) begin
            for (int i = 0; i < TOTAL_PARAMETERS; i++) begin
               if (w_offset == 24'(i)) begin
                  r_params[32*i +: 32] <= value;
               end
            end
         end
         if (enable && instruction == OP_READ) begin
            r_out <= w_is_param ? w_rd_param : core_output;
         end
      end
   end

   assign core_inputs  = r_params;
   assign output_value = r_out;

endmodule

// File: tb/tb_core_interface.sv
// Directed bench: two instances (windows 0..2 and 3..5) on one shared bus, each core modelled as p0 + p1.
module tb_core_interface;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  instr = 8'h00;
   logic [23:0] addr = 24'h0;
   logic [31:0] val = 32'h0;

   logic [31:0] ov_a, ov_b, co_a, co_b;
   logic        en_a, en_b;
   logic [63:0] ci_a, ci_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign co_a = ci_a[31:0] + ci_a[63:32];
   assign co_b = ci_b[31:0] + ci_b[63:32];

   core_interface #(.START_ADDRESS(0), .END_ADDRESS(2), .TOTAL_PARAMETERS(2)) u_a (
      .clock(clk), .reset(rst), .instruction(instr), .address(addr), .value(val),
      .output_value(ov_a), .enable(en_a), .core_inputs(ci_a), .core_output(co_a));

   core_interface #(.START_ADDRESS(3), .END_ADDRESS(5), .TOTAL_PARAMETERS(2)) u_b (
      .clock(clk), .reset(rst), .instruction(instr), .address(addr), .value(val),
      .output_value(ov_b), .enable(en_b), .core_inputs(ci_b), .core_output(co_b));

   task automatic bus(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
      @(negedge clk);
      instr = op;
      addr  = a;
      val   = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus(8'h00, 24'd0, 32'h0);
      tick();
      checks++; if (ci_a !== 64'h0) begin errors++; $display("FAIL reset_ci_a: got %h expected %h", ci_a, 64'h0); end
      checks++; if (ov_a !== 32'h0) begin errors++; $display("FAIL reset_ov_a: got %h expected %h", ov_a, 32'h0); end
      checks++; if (ci_b !== 64'h0) begin errors++; $display("FAIL reset_ci_b: got %h expected %h", ci_b, 64'h0); end
      checks++; if (en_a !== 1'b1) begin errors++; $display("FAIL enable_addr0: got %b expected 1", en_a); end
      bus(8'h00, 24'd3, 32'h0);
      #1;
      checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL enable_addr3: got %b expected 0", en_a); end
   endtask

   task automatic test_write_and_result();
      bus(8'h01, 24'd0, 32'd7);
      tick();
      checks++; if (ci_a !== 64'h0000_0000_0000_0007) begin errors++; $display("FAIL write_p0: got %h expected %h", ci_a, 64'h7); end
      checks++; if (ci_b !== 64'h0) begin errors++; $display("FAIL write_p0_other_inst: got %h expected %h", ci_b, 64'h0); end
      bus(8'h01, 24'd1, 32'd3);
      tick();
      checks++; if (ci_a !== 64'h0000_0003_0000_0007) begin errors++; $display("FAIL write_p1: got %h expected %h", ci_a, 64'h0000_0003_0000_0007); end
      bus(8'h02, 24'd2, 32'h0);
      #1;
      checks++; if (ov_a !== 32'h0) begin errors++; $display("FAIL read_result_before_edge: got %h expected %h", ov_a, 32'h0); end
      tick();
      checks++; if (ov_a !== 32'hA) begin errors++; $display("FAIL read_result: got %h expected %h", ov_a, 32'hA); end
   endtask

   task automatic test_read_params();
      bus(8'h02, 24'd0, 32'h0);
      tick();
      checks++; if (ov_a !== 32'd7) begin errors++; $display("FAIL read_p0: got %h expected %h", ov_a, 32'd7); end
      bus(8'h02, 24'd1, 32'h0);
      tick();
      checks++; if (ov_a !== 32'd3) begin errors++; $display("FAIL read_p1: got %h expected %h", ov_a, 32'd3); end
      bus(8'h02, 24'd2, 32'h0);
      tick();
      checks++; if (ov_a !== 32'd10) begin errors++; $display("FAIL read_result_again: got %h expected %h", ov_a, 32'd10); end
   endtask

   task automatic test_out_of_range();
      bus(8'h02, 24'd3, 32'h0);
      tick();
      checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL oor_enable: got %b expected 0", en_a); end
      checks++; if (ov_a !== 32'd10) begin errors++; $display("FAIL oor_hold: got %h expected %h", ov_a, 32'd10); end
      checks++; if (ov_b !== 32'd0) begin errors++; $display("FAIL oor_other_inst_read: got %h expected %h", ov_b, 32'd0); end
   endtask

   task automatic test_window_edges();
      logic [23:0] a_list [4];
      logic        e_list [4];
      a_list = '{24'd2, 24'd6, 24'd3, 24'd5};
      e_list = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         bus(8'h00, a_list[i], 32'h0);
         #1;
         checks++;
         if (en_b !== e_list[i]) begin
            errors++; $display("FAIL window_enable addr %0d: got %b expected %b", a_list[i], en_b, e_list[i]);
         end
      end
      bus(8'h01, 24'd2, 32'd9);
      tick();
      checks++; if (ci_b !== 64'h0) begin errors++; $display("FAIL write_below_window: got %h expected %h", ci_b, 64'h0); end
      checks++; if (ci_a !== 64'h0000_0003_0000_0007) begin errors++; $display("FAIL write_result_addr_a: got %h expected %h", ci_a, 64'h0000_0003_0000_0007); end
      bus(8'h01, 24'd5, 32'd9);
      tick();
      checks++; if (ci_b !== 64'h0) begin errors++; $display("FAIL write_result_addr_b: got %h expected %h", ci_b, 64'h0); end
      bus(8'h01, 24'd3, 32'h11);
      tick();
      bus(8'h01, 24'd4, 32'h22);
      tick();
      checks++; if (ci_b !== 64'h0000_0022_0000_0011) begin errors++; $display("FAIL write_b_params: got %h expected %h", ci_b, 64'h0000_0022_0000_0011); end
      bus(8'h02, 24'd5, 32'h0);
      tick();
      checks++; if (ov_b !== 32'h33) begin errors++; $display("FAIL read_b_result: got %h expected %h", ov_b, 32'h33); end
      checks++; if (ov_a !== 32'd10) begin errors++; $display("FAIL a_hold_on_b_read: got %h expected %h", ov_a, 32'd10); end
   endtask

   task automatic test_repeated();
      bus(8'h01, 24'd0, 32'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ci_a !== 64'h0000_0003_0000_0005) begin errors++; $display("FAIL repeat_write cycle %0d: got %h expected %h", i, ci_a, 64'h0000_0003_0000_0005); end
      end
      bus(8'h02, 24'd2, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (ov_a !== 32'd8) begin errors++; $display("FAIL repeat_read cycle %0d: got %h expected %h", i, ov_a, 32'd8); end
      end
      bus(8'h03, 24'd1, 32'd99);
      tick();
      checks++; if (ci_a !== 64'h0000_0003_0000_0005) begin errors++; $display("FAIL unknown_op_params: got %h expected %h", ci_a, 64'h0000_0003_0000_0005); end
      checks++; if (ov_a !== 32'd8) begin errors++; $display("FAIL unknown_op_hold: got %h expected %h", ov_a, 32'd8); end
      bus(8'h00, 24'd1, 32'd77);
      tick();
      checks++; if (ov_a !== 32'd8 || ci_a !== 64'h0000_0003_0000_0005) begin errors++; $display("FAIL nop_hold: got ov %h ci %h expected ov %h ci %h", ov_a, ci_a, 32'd8, 64'h0000_0003_0000_0005); end
   endtask

   task automatic test_async_reset();
      bus(8'h01, 24'd1, 32'h55);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ov_a !== 32'h0) begin errors++; $display("FAIL async_reset_ov_a: got %h expected %h", ov_a, 32'h0); end
      checks++; if (ci_a !== 64'h0) begin errors++; $display("FAIL async_reset_ci_a: got %h expected %h", ci_a, 64'h0); end
      checks++; if (ov_b !== 32'h0 || ci_b !== 64'h0) begin errors++; $display("FAIL async_reset_b: got ov %h ci %h expected 0", ov_b, ci_b); end
      tick();
      checks++; if (ci_a !== 64'h0) begin errors++; $display("FAIL reset_wins_write: got %h expected %h", ci_a, 64'h0); end
      @(negedge clk);
      rst   = 1'b0;
      instr = 8'h00;
      tick();
      checks++; if (ci_a !== 64'h0 || ov_a !== 32'h0) begin errors++; $display("FAIL after_reset: got ci %h ov %h expected 0", ci_a, ov_a); end
   endtask

   initial begin
      test_reset();
      test_write_and_result();
      test_read_params();
      test_out_of_range();
      test_window_edges();
      test_repeated();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
